// File: rtl/clk_ratio_monitor.sv
// Counts fastclk cycles per synchronised rising edge of a slow clock and, after a set
// number of slow edges, divides the fast count down to an integer fast/slow ratio.
module clk_ratio_monitor #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned REPORT_EDGES = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic             fastclk,
  input  logic             reset_l,
  input  logic             clk,
  output logic [CNT_W-1:0] fast_count,
  output logic [CNT_W-1:0] slow_count,
  output logic             done,
  output logic [CNT_W-1:0] ratio,
  output logic             ratio_valid
);

  localparam int unsigned    StepW   = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] Divisor = CNT_W'(REPORT_EDGES - 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(REPORT_EDGES - 1);

  typedef enum logic [1:0] {StMeasure, StDivide, StFinish, StIdle} state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               dly_q;
  logic               edge_pulse;
  logic               capture;
  logic [CNT_W-1:0]   fast_q, slow_q;
  logic [CNT_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   ratio_q, ratio_d;
  logic               valid_q, valid_d;
  logic [CNT_W:0]     rem_shift;
  logic               rem_ge;
  logic [CNT_W-1:0]   rem_sub;

  // Slow clock is plain data here: synchronise, then detect a 0->1 at the last stage.
  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign done       = (state_q != StMeasure);
  assign capture    = edge_pulse && !done && (slow_q == LastCnt);

  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      fast_q <= '0;
      slow_q <= '0;
    end else if (!done) begin
      // The capturing cycle itself is not counted; the dividend is the pre-capture value.
      if (!capture) fast_q <= fast_q + CNT_W'(1);
      if (edge_pulse) slow_q <= slow_q + CNT_W'(1);
    end
  end

  // Restoring divider: remainder stays below the divisor, so the subtraction fits in CNT_W.
  assign rem_shift = {rem_q, quo_q[CNT_W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, Divisor});
  assign rem_sub   = rem_shift[CNT_W-1:0] - Divisor;

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    step_d  = step_q;
    ratio_d = ratio_q;
    valid_d = valid_q;
    unique case (state_q)
      StMeasure: begin
        if (capture) begin
          quo_d   = fast_q;
          rem_d   = '0;
          step_d  = '0;
          state_d = StDivide;
        end
      end
      StDivide: begin
        quo_d  = {quo_q[CNT_W-2:0], rem_ge};
        rem_d  = rem_ge ? rem_sub : rem_shift[CNT_W-1:0];
        step_d = step_q + StepW'(1);
        if (step_q == StepW'(CNT_W - 1)) state_d = StFinish;
      end
      StFinish: begin
        ratio_d = quo_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      StIdle: begin
      end
      default: state_d = StMeasure;
    endcase
  end

  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StMeasure;
      quo_q   <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      ratio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      ratio_q <= ratio_d;
      valid_q <= valid_d;
    end
  end

  assign fast_count  = fast_q;
  assign slow_count  = slow_q;
  assign ratio       = ratio_q;
  assign ratio_valid = valid_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: two instances (4 and 2 report edges) share clocks and reset;
// expected counts are predicted when the bench drives the slow edges and checked at ratio_valid.
module tb_clk_ratio_monitor;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SYNC  = 2;
  localparam int          RE0   = 4;
  localparam int          RE1   = 2;

  logic             fastclk = 1'b0;
  logic             reset_l = 1'b0;
  logic             clk     = 1'b0;
  logic [CNT_W-1:0] fcnt [2];
  logic [CNT_W-1:0] scnt [2];
  logic [CNT_W-1:0] rat  [2];
  logic             dn   [2];
  logic             rv   [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gen_per  = 0;
  int ph       = 0;
  int rises    = 0;
  int q0[$];
  int q1[$];
  bit seen_done  [2];
  bit seen_valid [2];
  int done_cyc   [2];
  int last_fast  [2];

  always #5 fastclk = ~fastclk;

  clk_ratio_monitor #(.CNT_W(CNT_W), .REPORT_EDGES(RE0), .SYNC_STAGES(SYNC)) dut0 (
    .fastclk(fastclk), .reset_l(reset_l), .clk(clk),
    .fast_count(fcnt[0]), .slow_count(scnt[0]), .done(dn[0]),
    .ratio(rat[0]), .ratio_valid(rv[0])
  );

  clk_ratio_monitor #(.CNT_W(CNT_W), .REPORT_EDGES(RE1), .SYNC_STAGES(SYNC)) dut1 (
    .fastclk(fastclk), .reset_l(reset_l), .clk(clk),
    .fast_count(fcnt[1]), .slow_count(scnt[1]), .done(dn[1]),
    .ratio(rat[1]), .ratio_valid(rv[1])
  );

  function automatic int re_of(input int i);
    return (i == 0) ? RE0 : RE1;
  endfunction

  // One fastclk cycle: sample just after the edge, score, then drive the slow clock.
  task automatic step();
    int  e;
    bit  have;
    bit  nclk;
    @(posedge fastclk);
    #1;
    cyc = reset_l ? cyc + 1 : 0;
    for (int i = 0; i < 2; i++) begin
      if (!rv[i]) begin
        checks++;
        if (rat[i] !== '0) begin
          failures++;
          $display("FAIL ratio_before_valid dut%0d: got %0d want 0", i, rat[i]);
        end
      end
      if (dn[i] && !seen_done[i]) begin
        seen_done[i] = 1'b1;
        done_cyc[i]  = cyc;
      end
      if (rv[i] && !seen_valid[i]) begin
        seen_valid[i] = 1'b1;
        checks++;
        if (!seen_done[i] || (cyc - done_cyc[i]) != CNT_W + 1) begin
          failures++;
          $display("FAIL valid_latency dut%0d: got %0d want %0d", i, cyc - done_cyc[i], CNT_W + 1);
        end
        have = 1'b0;
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
          failures++;
          $display("FAIL unexpected_valid dut%0d: got valid want no result", i);
        end else begin
          last_fast[i] = e;
          if (fcnt[i] !== CNT_W'(e)) begin
            failures++;
            $display("FAIL fast_count dut%0d: got %0d want %0d", i, fcnt[i], e);
          end
          checks++;
          if (scnt[i] !== CNT_W'(re_of(i))) begin
            failures++;
            $display("FAIL slow_count dut%0d: got %0d want %0d", i, scnt[i], re_of(i));
          end
          checks++;
          if (rat[i] !== CNT_W'(e / (re_of(i) - 1))) begin
            failures++;
            $display("FAIL ratio dut%0d: got %0d want %0d", i, rat[i], e / (re_of(i) - 1));
          end
          $display("fastclk is %0d times faster than clk", rat[i]);
        end
      end
    end
    if (gen_per != 0) begin
      ph   = (ph + 1) % gen_per;
      nclk = (ph >= gen_per / 2);
      if (nclk && !clk && reset_l) begin
        rises++;
        // Edge reaches the counters SYNC cycles after the driven rise; capture skips one count.
        if (rises == RE0) q0.push_back(cyc + SYNC);
        if (rises == RE1) q1.push_back(cyc + SYNC);
      end
      clk = nclk;
    end
  endtask

  task automatic start(input int per);
    reset_l = 1'b0;
    gen_per = 0;
    clk     = 1'b0;
    repeat (3) step();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      seen_done[i]  = 1'b0;
      seen_valid[i] = 1'b0;
      done_cyc[i]   = 0;
    end
    rises   = 0;
    ph      = per / 2 - 1;
    gen_per = per;
    reset_l = 1'b1;
  endtask

  task automatic run_until_valid(input int maxc);
    int n = 0;
    while (!(seen_valid[0] && seen_valid[1]) && n < maxc) begin
      step();
      n++;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!seen_valid[i]) begin
        failures++;
        $display("FAIL timeout dut%0d: got no ratio_valid want one within %0d cycles", i, maxc);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (fcnt[i] !== '0 || scnt[i] !== '0 || dn[i] !== 1'b0 || rat[i] !== '0 || rv[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s dut%0d: got fc=%0d sc=%0d done=%b ratio=%0d rv=%b want all 0",
                 tag, i, fcnt[i], scnt[i], dn[i], rat[i], rv[i]);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [CNT_W-1:0] got, input int want);
    checks++;
    if (got !== CNT_W'(want)) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    gen_per = 4;
    ph      = 0;
    repeat (12) step();
    check_all_zero("reset_hold");
  endtask

  task automatic test_period8();
    start(8);
    run_until_valid(400);
    check_val("p8_fast_dut0", fcnt[0], 27);
    check_val("p8_ratio_dut0", rat[0], 9);
    check_val("p8_fast_dut1", fcnt[1], 11);
    check_val("p8_ratio_dut1", rat[1], 11);
  endtask

  task automatic test_period20();
    start(20);
    run_until_valid(600);
    check_val("p20_fast_dut0", fcnt[0], 63);
    check_val("p20_ratio_dut0", rat[0], 21);
  endtask

  task automatic test_idle_after_done();
    repeat (10 * gen_per) step();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("idle_fast_dut%0d", i), fcnt[i], last_fast[i]);
      check_val($sformatf("idle_slow_dut%0d", i), scnt[i], re_of(i));
      check_val($sformatf("idle_ratio_dut%0d", i), rat[i], last_fast[i] / (re_of(i) - 1));
      checks++;
      if (dn[i] !== 1'b1 || rv[i] !== 1'b1) begin
        failures++;
        $display("FAIL idle_flags dut%0d: got done=%b rv=%b want 1 1", i, dn[i], rv[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge fastclk);
    #3;
    reset_l = 1'b0;
    #1;
    check_all_zero("async_reset");
  endtask

  task automatic test_mid_divide_reset();
    int n = 0;
    start(8);
    while (!seen_done[0] && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (!seen_done[0]) begin
      failures++;
      $display("FAIL mid_divide_done: got done=0 want 1 within 400 cycles");
    end
    repeat (10) step();
    @(posedge fastclk);
    #3;
    reset_l = 1'b0;
    #1;
    check_val("mid_div_ratio", rat[0], 0);
    checks++;
    if (rv[0] !== 1'b0 || dn[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_div_flags: got done=%b rv=%b want 0 0", dn[0], rv[0]);
    end
    start(8);
    run_until_valid(400);
    check_val("rerun_fast_dut0", fcnt[0], 27);
    check_val("rerun_ratio_dut0", rat[0], 9);
  endtask

  task automatic test_re2_period6();
    start(6);
    run_until_valid(400);
    check_val("p6_fast_dut1", fcnt[1], 9);
    check_val("p6_ratio_dut1", rat[1], 9);
    check_val("p6_slow_dut1", scnt[1], 2);
    check_val("p6_ratio_dut0", rat[0], 7);
  endtask

  initial begin
    test_reset();
    test_period8();
    test_period20();
    test_idle_after_done();
    test_async_reset();
    test_mid_divide_reset();
    test_re2_period6();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
- Measures how many fast-clock cycles elapse per slow-clock edge.
- Runs entirely in the fastclk domain. The slow clock `clk` is treated as a sampled data input: it is synchronised and then edge-detected.
- After a programmable number of slow edges it freezes its counters and computes an integer ratio with a sequential divider.
- Used as a clock-relationship sanity monitor beside the top-level datapath.

Parameters:
- CNT_W, 32, width of all counters and of the ratio.
- REPORT_EDGES, 4, number of slow rising edges (counted from reset release) that ends measurement; legal range is 2 or more.
- SYNC_STAGES, 2, depth of the synchroniser on `clk`; legal range is 2 or more.

Ports:
- fastclk  in  1  Sole clock. All flops are rising-edge triggered on it.
- reset_l  in  1  Asynchronous, active-low reset.
- clk  in  1  Slow clock, sampled as data. Its frequency must be at most fastclk/4.
- fast_count  out  CNT_W  Fastclk cycles counted since reset release; frozen once done.
- slow_count  out  CNT_W  Synchronised rising edges of `clk` counted since reset release; frozen once done.
- done  out  1  Sticky flag: measurement complete.
- ratio  out  CNT_W  Value of fast_count / (REPORT_EDGES-1) at capture, truncated.
- ratio_valid  out  1  Sticky flag: `ratio` holds its final value.

Behaviour:
- Reset (reset_l=0, asynchronous): all counters, the synchroniser chain, the edge-detect flop, the divider state, ratio, done and ratio_valid go to 0.
- Synchroniser: `clk` passes through SYNC_STAGES flops. A rising edge is detected when the last synchroniser stage is 1 and a delay flop after it holds 0. The edge-detect pulse is exactly one fastclk cycle wide.
- fast_count: increments by 1 every fastclk cycle while done=0. Wraps modulo 2^CNT_W; no saturation.
- slow_count: increments by 1 on each edge pulse while done=0.
- Capture, on the cycle where an edge pulse occurs with done=0 and slow_count == REPORT_EDGES-1 (value before increment):
  - slow_count increments to REPORT_EDGES.
  - fast_count does not increment and is frozen from this cycle.
  - The divider loads dividend = fast_count (current value) and divisor = REPORT_EDGES-1.
  - done is set to 1 in the next cycle and stays 1 until reset.
- Divider: restoring shift-subtract, one quotient bit per cycle, CNT_W cycles. Divide-by-zero cannot occur because the divisor is at least 1.
- On completion: ratio <= quotient and ratio_valid <= 1 in the same cycle, i.e. CNT_W+1 cycles after done rises. The remainder is discarded. ratio is 0 until ratio_valid=1.
- After completion the block is idle: counters hold, and further `clk` edges are ignored.
- Reset mid-measurement or mid-divide: everything clears asynchronously. On reset release, counting restarts from 0 and the synchroniser refills before any new edge can be detected.
- Edge detection needs at least 2 fastclk cycles of `clk` high and 2 of `clk` low; narrower pulses may be missed and are not counted.
- Simulation-only, under a translate_off region: on the ratio_valid rising cycle, display "fastclk is <ratio> times faster than clk". This is not synthesised.

Test Plan:
- Hold reset_l=0 while toggling `clk` -> all outputs are 0. Assert reset_l=0 asynchronously mid-cycle -> outputs clear immediately, without waiting for a fastclk edge.
- `clk` period = 8 fastclk cycles, reset released -> done rises after the 4th synchronised edge, slow_count=4. Bench checks ratio == floor(fast_count/3) after ratio_valid. With reset released 1 cycle before `clk` rises, expect fast_count=27 and ratio=9.
- `clk` period = 20 fastclk cycles -> ratio == floor(fast_count/3), approximately 20. ratio_valid rises exactly CNT_W+1=33 cycles after done.
- After done, keep toggling `clk` for 10 more periods -> fast_count, slow_count and ratio stay unchanged.
- Assert reset mid-divide, at cycle 10 of 32, then release -> ratio=0 and ratio_valid=0. The measurement reruns and produces a fresh correct result.
- REPORT_EDGES=2, `clk` period = 6 fastclk cycles -> done after 2 edges, ratio == fast_count/1 (divisor 1, so ratio equals fast_count).
